sd_gather_fl: RTL and testbench
===============================

# sd_gather_fl

Many-to-one gather stage: the inverse of the destination-masked mirror fork. It collects exactly one srdy/drdy transfer from each source selected by a source mask, holds each in a per-source slot, and presents all of them together as one wide output transfer. It sits at the join point after a mirrored broadcast, recombining per-lane responses before a single downstream consumer. All outputs come straight from flops, so it also breaks every timing path between sources and consumer.

## Interface
- mirror, 2, number of source ports (≥2)
- width, 8, data width per source
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- c_srdy  in  mirror  per-source valid
- c_drdy  out  mirror  per-source ready
- c_data  in  mirror×width  per-source data, packed; source i at [i*width +: width]
- c_src_vld  in  mirror  sources participating in the next gather; sampled only in IDLE
- p_srdy  out  1  gathered word valid
- p_drdy  in  1  consumer ready
- p_data  out  mirror×width  gathered data, same packing as c_data
- p_src_vld  out  mirror  latched mask for the word being presented

## Operation
- State: st ∈ {IDLE, COLLECT, FULL}; msk[mirror]; filled[mirror]; slot data regs.
- IDLE: c_drdy=0, p_srdy=0. If c_src_vld≠0: msk←c_src_vld, filled←0, clear all slot data to 0, go COLLECT. If c_src_vld=0: stay IDLE.
- COLLECT: c_drdy[i] = msk[i] & ~filled[i]. A transfer on source i (c_srdy[i]&c_drdy[i]) loads slot i and sets filled[i]. Any number of sources may transfer in the same cycle. When (filled | this-cycle transfers) covers msk, go FULL at that edge.
- FULL: c_drdy=0, p_srdy=1, p_data=slots, p_src_vld=msk. When p_drdy=1, go IDLE; filled←0, msk←0.
- Unmasked slots read 0 in p_data. c_srdy on unmasked or already-filled sources is ignored and not acknowledged.
- c_src_vld changes during COLLECT/FULL are ignored. c_data on non-transferring cycles is don't-care.
- c_drdy, p_srdy, p_data, p_src_vld are functions of flops only. No combinational path from any input to any output.

## Timing
- Reset (asynchronous, any state): st=IDLE, msk=0, filled=0, slots=0. Outputs: c_drdy=0, p_srdy=0, p_data=0, p_src_vld=0. A partially gathered word is discarded. Sources mid-handshake see c_drdy drop immediately.
- IDLE→COLLECT: 1 cycle after a nonzero c_src_vld is sampled. c_drdy rises in the cycle after that sample.
- Last source transfer at edge N → p_srdy=1 from edge N onward (first visible cycle N+1).
- p_srdy stays high, with p_data stable, until the p_drdy edge. p_srdy=0 in the following cycle.
- Minimum gather period with all sources and consumer always ready: 3 cycles (IDLE, COLLECT, FULL).
- Source i is acknowledged exactly once per gather.

## Test plan
- mirror=2, width=8. Reset mid-COLLECT with slot0=0xAA filled → all outputs 0 immediately. After reset, c_src_vld=2'b11 gives c_drdy=2'b11 two cycles later; the old 0xAA never appears.
- c_src_vld=2'b11; src0 sends 0x11 at cycle 2, src1 sends 0x22 at cycle 5, p_drdy=1 → p_srdy high for exactly one cycle, at cycle 6, with p_data=0x2211 and p_src_vld=2'b11. c_drdy[0] low from cycle 3.
- c_src_vld=2'b10; src0 asserts c_srdy with 0x55 throughout, src1 sends 0x66 → c_drdy[0] never high; p_data=0x6600, p_src_vld=2'b10.
- Both sources and consumer always ready, both mask bits set, incrementing data → one gather every 3 cycles, no word lost or duplicated over 100 gathers.
- In FULL with p_drdy=0 for 10 cycles while c_srdy=2'b11 and c_src_vld toggles → c_drdy=0 throughout; p_data and p_src_vld stay stable; a single transfer occurs on p_drdy=1.
- c_src_vld=0 held for 20 cycles with c_srdy=2'b11 → stays in IDLE; c_drdy=0 and p_srdy=0 the whole time.

Source files
------------

// File: rtl/sd_gather_fl.sv
`default_nettype none
// ============================================================================
//  Module   : sd_gather_fl
//  Brief    : Many-to-one srdy/drdy gather stage. Collects one transfer from
//             every source selected by a latched source mask, then presents
//             all slots together as one wide output word. All outputs are
//             driven from flops only.
//  Revision : 1.0 - initial release
// ============================================================================
module sd_gather_fl #(
   parameter int MIRROR = 2,
   parameter int WIDTH  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [MIRROR-1:0]         c_srdy,
   output logic [MIRROR-1:0]         c_drdy,
   input  logic [MIRROR*WIDTH-1:0]   c_data,
   input  logic [MIRROR-1:0]         c_src_vld,
   output logic                      p_srdy,
   input  logic                      p_drdy,
   output logic [MIRROR*WIDTH-1:0]   p_data,
   output logic [MIRROR-1:0]         p_src_vld
);

   localparam logic [1:0] C_ST_IDLE    = 2'd0;
   localparam logic [1:0] C_ST_COLLECT = 2'd1;
   localparam logic [1:0] C_ST_FULL    = 2'd2;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [MIRROR-1:0] r_msk;
   logic [MIRROR-1:0] r_filled;
   logic [MIRROR-1:0] w_drdy;
   logic [MIRROR-1:0] w_xfer;
   logic              w_done;
   logic              w_start;
   logic              w_release;

   // Ready only toward masked sources that have not yet delivered; decoded
   // purely from flops so no input reaches c_drdy combinationally.
   assign w_drdy    = (r_state == C_ST_COLLECT) ? (r_msk & ~r_filled) : '0;
   assign w_xfer    = c_srdy & w_drdy;
   // Word is complete once earlier and this-cycle transfers cover the mask.
   assign w_done    = ((r_filled | w_xfer) & r_msk) == r_msk;
   assign w_start   = (r_state == C_ST_IDLE) && (c_src_vld != '0);
   assign w_release = (r_state == C_ST_FULL) && p_drdy;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= C_ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         C_ST_IDLE:    if (c_src_vld != '0) w_state_nxt = C_ST_COLLECT;
         C_ST_COLLECT: if (w_done)          w_state_nxt = C_ST_FULL;
         C_ST_FULL:    if (p_drdy)          w_state_nxt = C_ST_IDLE;
         default:                           w_state_nxt = C_ST_IDLE;
      endcase
   end

   // Handshake outputs, decoded from state and mask/fill flops.
   always_comb begin
      c_drdy = w_drdy;
      p_srdy = (r_state == C_ST_FULL);
   end

   // Source mask and fill tracking for the gather in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_msk    <= '0;
         r_filled <= '0;
      end else if (w_start) begin
         r_msk    <= c_src_vld;
         r_filled <= '0;
      end else if (w_release) begin
         r_msk    <= '0;
         r_filled <= '0;
      end else begin
         r_filled <= r_filled | w_xfer;
      end
   end

   assign p_src_vld = r_msk;

   // One data slot per source; cleared at gather start so unmasked lanes
   // present zero.
   for (genvar gi = 0; gi < MIRROR; gi++) begin : g_slot
      logic [WIDTH-1:0] r_slot;

      // Slot load on this source's accepted transfer.
      always_ff @(posedge clk or posedge reset) begin
         if (reset)            r_slot <= '0;
         else if (w_start)     r_slot <= '0;
         else if (w_xfer[gi])  r_slot <= c_data[gi*WIDTH +: WIDTH];
      end

      assign p_data[gi*WIDTH +: WIDTH] = r_slot;
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_gather_fl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sd_gather_fl
//  Brief    : Self-checking bench for sd_gather_fl, directed scenarios plus
//             randomized traffic against a transaction-level gather model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sd_gather_fl;

   localparam int MIRROR = 2;
   localparam int WIDTH  = 8;

   logic                    clk = 1'b0;
   logic                    reset;
   logic [MIRROR-1:0]       c_srdy;
   logic [MIRROR-1:0]       c_drdy;
   logic [MIRROR*WIDTH-1:0] c_data;
   logic [MIRROR-1:0]       c_src_vld;
   logic                    p_srdy;
   logic                    p_drdy;
   logic [MIRROR*WIDTH-1:0] p_data;
   logic [MIRROR-1:0]       p_src_vld;

   always #5 clk = ~clk;

   sd_gather_fl #(.MIRROR(MIRROR), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .c_srdy    (c_srdy),
      .c_drdy    (c_drdy),
      .c_data    (c_data),
      .c_src_vld (c_src_vld),
      .p_srdy    (p_srdy),
      .p_drdy    (p_drdy),
      .p_data    (p_data),
      .p_src_vld (p_src_vld)
   );

   int n_checks = 0;
   int n_errors = 0;
   int dut_xfers = 0;

   // Reference model: a gather is either not started, waiting on a set of
   // owed sources, or a finished word waiting for the consumer.
   bit               m_waiting;
   bit               m_presenting;
   logic [MIRROR-1:0] m_mask;
   logic [MIRROR-1:0] m_owed;
   logic [WIDTH-1:0] m_word [MIRROR];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [MIRROR*WIDTH-1:0] model_word();
      logic [MIRROR*WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < MIRROR; i++) w[i*WIDTH +: WIDTH] = m_word[i];
      return w;
   endfunction

   task automatic model_reset();
      m_waiting    = 0;
      m_presenting = 0;
      m_mask       = '0;
      m_owed       = '0;
      for (int i = 0; i < MIRROR; i++) m_word[i] = '0;
   endtask

   // One clock cycle: check outputs against the model, apply inputs,
   // advance the model by what the inputs imply, then cross the edge.
   task automatic step(input logic [MIRROR-1:0] s, input logic [MIRROR-1:0] v,
                       input logic [MIRROR*WIDTH-1:0] d, input logic pd);
      check_val("c_drdy", c_drdy, m_waiting ? m_owed : '0);
      check_val("p_srdy", p_srdy, m_presenting);
      if (m_presenting) begin
         check_val("p_data", p_data, model_word());
         check_val("p_src_vld", p_src_vld, m_mask);
      end
      if (p_srdy === 1'b1 && pd) dut_xfers++;
      c_srdy = s; c_src_vld = v; c_data = d; p_drdy = pd;
      if (m_presenting) begin
         if (pd) begin
            m_presenting = 0;
            m_mask       = '0;
         end
      end else if (m_waiting) begin
         for (int i = 0; i < MIRROR; i++)
            if (m_owed[i] && s[i]) begin
               m_word[i] = d[i*WIDTH +: WIDTH];
               m_owed[i] = 1'b0;
            end
         if (m_owed == '0) begin
            m_waiting    = 0;
            m_presenting = 1;
         end
      end else if (v != '0) begin
         m_waiting = 1;
         m_mask    = v;
         m_owed    = v;
         for (int i = 0; i < MIRROR; i++) m_word[i] = '0;
      end
      @(negedge clk);
   endtask

   // Let any gather in progress finish with fully cooperative sources.
   task automatic drain();
      int guard = 0;
      while ((m_waiting || m_presenting) && guard < 20) begin
         step('1, '0, 16'hBEEF, 1'b1);
         guard++;
      end
      check_val("drain_bound", (m_waiting || m_presenting), 0);
   endtask

   int base;

   initial begin
      reset = 1'b1; c_srdy = '0; c_src_vld = '0; c_data = '0; p_drdy = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_val("rst_c_drdy", c_drdy, 0);
      check_val("rst_p_srdy", p_srdy, 0);
      check_val("rst_p_data", p_data, 0);
      check_val("rst_p_src_vld", p_src_vld, 0);
      reset = 1'b0;

      // Reset in the middle of a gather with slot 0 already holding 0xAA.
      step(2'b00, 2'b11, 16'h0000, 1'b0);
      step(2'b01, 2'b00, 16'h00AA, 1'b0);
      step(2'b00, 2'b00, 16'h0000, 1'b0);
      #2 reset = 1'b1;
      #1;
      check_val("arst_c_drdy", c_drdy, 0);
      check_val("arst_p_srdy", p_srdy, 0);
      check_val("arst_p_data", p_data, 0);
      check_val("arst_p_src_vld", p_src_vld, 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      step(2'b00, 2'b11, 16'h0000, 1'b0);
      step(2'b00, 2'b00, 16'h0000, 1'b0);
      check_val("post_rst_c_drdy", c_drdy, 2'b11);
      step(2'b10, 2'b00, 16'h4400, 1'b0);
      step(2'b01, 2'b00, 16'h0033, 1'b0);
      check_val("no_stale_aa", p_data, 16'h4433);
      step(2'b00, 2'b00, 16'h0000, 1'b1);

      // Staggered sources: src0 early, src1 three cycles later.
      step(2'b00, 2'b11, 16'h0000, 1'b1);
      step(2'b01, 2'b00, 16'h0011, 1'b1);
      for (int i = 0; i < 2; i++) step(2'b00, 2'b00, 16'h0000, 1'b1);
      step(2'b10, 2'b00, 16'h2200, 1'b1);
      check_val("stagger_p_data", p_data, 16'h2211);
      step(2'b00, 2'b00, 16'h0000, 1'b1);
      check_val("stagger_one_cycle", p_srdy, 0);

      // Partial mask: src0 pushes throughout but is never acknowledged.
      step(2'b01, 2'b10, 16'h0055, 1'b0);
      step(2'b01, 2'b00, 16'h0055, 1'b0);
      step(2'b11, 2'b00, 16'h6655, 1'b0);
      check_val("partial_p_data", p_data, 16'h6600);
      check_val("partial_p_src_vld", p_src_vld, 2'b10);

      // Consumer stall in FULL while sources push and the mask input toggles.
      for (int i = 0; i < 10; i++)
         step(2'b11, (i % 2) ? 2'b11 : 2'b01, 16'h7777 + 16'(i), 1'b0);
      base = dut_xfers;
      step(2'b11, 2'b11, 16'h0000, 1'b1);
      check_val("stall_single_xfer", dut_xfers - base, 1);
      drain();

      // Idle hold: no mask, sources busy.
      for (int i = 0; i < 20; i++) step(2'b11, 2'b00, 16'h1234, 1'b1);

      // Throughput: one gather every three cycles with everything ready.
      base = dut_xfers;
      for (int i = 0; i < 300; i++) step(2'b11, 2'b11, {8'(2*i+1), 8'(2*i)}, 1'b1);
      check_val("throughput_100", dut_xfers - base, 100);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         step(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom),
              16'($urandom), 1'($urandom));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
